// File: rtl/processor_controller_if.sv
`default_nettype none
// ==========================================================================
// processor_controller_if: controller <-> datapath control bundle.  Rev 1.0
// ==========================================================================
interface processor_controller_if #(
  parameter int DATA_W = 10,
  parameter int NREG   = 4
);
  logic              Run;
  logic [DATA_W-1:0] raw_data;
  logic [DATA_W-1:0] IR;
  logic [1:0]        Tstep;
  logic              IRin;
  logic [NREG-1:0]   Rin;
  logic [NREG-1:0]   Rout;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic              Extern;
  logic              Immout;
  logic [DATA_W-1:0] Imm;
  logic [3:0]        ALU_fn;
  logic              Done;
  logic              Illegal;

  modport master (
    input  Run, raw_data,
    output IR, Tstep, IRin, Rin, Rout, Ain, Gin, Gout, Extern, Immout,
           Imm, ALU_fn, Done, Illegal
  );

  modport slave (
    output Run, raw_data,
    input  IR, Tstep, IRin, Rin, Rout, Ain, Gin, Gout, Extern, Immout,
           Imm, ALU_fn, Done, Illegal
  );
endinterface
`default_nettype wire

// File: rtl/processor_controller.sv
`default_nettype none
// ==========================================================================
// processor_controller: IR + timestep FSM decoding the 10-bit ISA.  Rev 1.0
// ==========================================================================
module processor_controller #(
  parameter int DATA_W = 10,
  parameter int NREG   = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          Clear,
  processor_controller_if.master        bus
);

  typedef enum logic [1:0] {TS0 = 2'd0, TS1 = 2'd1, TS2 = 2'd2, TS3 = 2'd3} tstep_t;
  typedef enum logic [2:0] {K_LD, K_CP, K_UN, K_BIN, K_IMM, K_ILL} kind_t;

  tstep_t            r_tstep, w_tstep_nxt;
  logic [DATA_W-1:0] r_ir;

  logic [1:0]      w_class, w_x, w_y;
  logic [3:0]      w_fn;
  kind_t           w_kind;
  logic [NREG-1:0] w_x_oh, w_y_oh;
  logic            w_irin, w_ain, w_gin, w_gout, w_extern, w_immout, w_done, w_illegal;
  logic [NREG-1:0] w_rin, w_rout;
  logic [3:0]      w_alu_fn;

  assign w_class = r_ir[DATA_W-1:DATA_W-2];
  assign w_x     = r_ir[7:6];
  assign w_y     = r_ir[5:4];
  assign w_fn    = r_ir[3:0];

  always_ff @(posedge CLOCK_50) begin
    if (Clear) begin
      r_tstep <= TS0;
      r_ir    <= '0;
    end else begin
      r_tstep <= w_tstep_nxt;
      if (w_irin) r_ir <= bus.raw_data;
    end
  end

  always_comb begin
    w_kind = K_ILL;
    case (w_class)
      2'b00: begin
        case (w_fn)
          4'b0000:                   w_kind = K_LD;
          4'b0001:                   w_kind = K_CP;
          4'b0100, 4'b0101:          w_kind = K_UN;
          4'b0010, 4'b0011,
          4'b0110, 4'b0111, 4'b1000,
          4'b1001, 4'b1010, 4'b1011: w_kind = K_BIN;
          default:                   w_kind = K_ILL;
        endcase
      end
      2'b10, 2'b11: w_kind = K_IMM;
      default:      w_kind = K_ILL;
    endcase
  end

  always_comb begin
    w_x_oh       = '0;
    w_x_oh[w_x]  = 1'b1;
    w_y_oh       = '0;
    w_y_oh[w_y]  = 1'b1;
  end

  // ALU function is presented for the whole instruction so G captures the right result.
  always_comb begin
    w_alu_fn = 4'b0000;
    if (r_tstep != TS0) begin
      case (w_class)
        2'b00:   w_alu_fn = w_fn;
        2'b10:   w_alu_fn = 4'b0010;
        2'b11:   w_alu_fn = 4'b0011;
        default: w_alu_fn = 4'b0000;
      endcase
    end
  end

  always_comb begin
    w_tstep_nxt = r_tstep;
    w_irin      = 1'b0;
    w_rin       = '0;
    w_rout      = '0;
    w_ain       = 1'b0;
    w_gin       = 1'b0;
    w_gout      = 1'b0;
    w_extern    = 1'b0;
    w_immout    = 1'b0;
    w_done      = 1'b0;
    w_illegal   = 1'b0;
    case (r_tstep)
      TS0: begin
        if (bus.Run) begin
          w_irin      = 1'b1;
          w_tstep_nxt = TS1;
        end
      end
      TS1: begin
        case (w_kind)
          K_LD:  begin w_extern = 1'b1; w_rin = w_x_oh; w_done = 1'b1; end
          K_CP:  begin w_rout = w_y_oh; w_rin = w_x_oh; w_done = 1'b1; end
          K_UN:  begin w_rout = w_y_oh; w_gin = 1'b1; w_tstep_nxt = TS2; end
          K_BIN,
          K_IMM: begin w_rout = w_x_oh; w_ain = 1'b1; w_tstep_nxt = TS2; end
          default: begin w_done = 1'b1; w_illegal = 1'b1; end
        endcase
      end
      TS2: begin
        case (w_kind)
          K_UN:  begin w_gout = 1'b1; w_rin = w_x_oh; w_done = 1'b1; end
          K_BIN: begin w_rout = w_y_oh; w_gin = 1'b1; w_tstep_nxt = TS3; end
          K_IMM: begin w_immout = 1'b1; w_gin = 1'b1; w_tstep_nxt = TS3; end
          default: w_tstep_nxt = TS0;
        endcase
      end
      TS3: begin
        if (w_kind == K_BIN || w_kind == K_IMM) begin
          w_gout = 1'b1;
          w_rin  = w_x_oh;
          w_done = 1'b1;
        end else begin
          w_tstep_nxt = TS0;
        end
      end
      default: w_tstep_nxt = TS0;
    endcase
    if (w_done) w_tstep_nxt = TS0;
  end

  assign bus.IR      = r_ir;
  assign bus.Tstep   = r_tstep;
  assign bus.IRin    = w_irin;
  assign bus.Rin     = w_rin;
  assign bus.Rout    = w_rout;
  assign bus.Ain     = w_ain;
  assign bus.Gin     = w_gin;
  assign bus.Gout    = w_gout;
  assign bus.Extern  = w_extern;
  assign bus.Immout  = w_immout;
  assign bus.Imm     = {{(DATA_W-6){1'b0}}, r_ir[5:0]};
  assign bus.ALU_fn  = w_alu_fn;
  assign bus.Done    = w_done;
  assign bus.Illegal = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_processor_controller.sv
`default_nettype none
// ==========================================================================
// tb_processor_controller: scoreboard bench for the processor controller.
// ==========================================================================
module tb_processor_controller;

  logic clk;
  logic clear;
  int   n_checks;
  int   n_errors;
  logic mon_en;

  processor_controller_if #(.DATA_W(10), .NREG(4)) bus ();

  processor_controller #(.DATA_W(10), .NREG(4)) dut (
    .CLOCK_50 (clk),
    .Clear    (clear),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic [9:0] raw;
    logic       clr;
  } stim_t;

  typedef struct {
    string      nm;
    logic [1:0] ts;
    logic [9:0] ir;
    logic [9:0] imm;
    logic [19:0] ctl;
  } exp_t;

  stim_t stim_q[$];
  exp_t  sb[$];

  logic [19:0] act;
  assign act = {bus.IRin, bus.Rin, bus.Rout, bus.Ain, bus.Gin, bus.Gout,
                bus.Extern, bus.Immout, bus.ALU_fn, bus.Done, bus.Illegal};

  localparam logic [19:0] Z = 20'h0;

  function automatic logic [19:0] mk(input logic irin, input logic [3:0] rin,
                                     input logic [3:0] rout, input logic ain,
                                     input logic gin, input logic gout,
                                     input logic ext, input logic immo,
                                     input logic [3:0] fn, input logic done,
                                     input logic ill);
    return {irin, rin, rout, ain, gin, gout, ext, immo, fn, done, ill};
  endfunction

  task automatic push(input logic run, input logic [9:0] raw, input logic clr,
                      input logic [1:0] ts, input logic [9:0] ir,
                      input logic [19:0] ctl, input string nm);
    stim_t s;
    exp_t  e;
    s.run = run; s.raw = raw; s.clr = clr;
    stim_q.push_back(s);
    e.nm = nm; e.ts = ts; e.ir = ir; e.imm = {4'b0000, ir[5:0]}; e.ctl = ctl;
    sb.push_back(e);
  endtask

  // Bus ownership and one-hot enables, every cycle once reset has settled.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if ((32'(bus.Extern) + 32'(bus.Immout) + 32'(bus.Gout) + 32'(|bus.Rout)) > 1 ||
          !$onehot0(bus.Rin) || !$onehot0(bus.Rout)) begin
        n_errors++;
        $display("FAIL bus_invariant: got Ext=%b Imm=%b Gout=%b Rout=%b Rin=%b, required one driver max and one-hot enables",
                 bus.Extern, bus.Immout, bus.Gout, bus.Rout, bus.Rin);
      end
    end
  end

  task automatic test_reset();
    stim_t s; exp_t e;
    push(0, 10'h000, 0, 2'd0, 10'h000, Z, "reset_idle0");
    push(0, 10'h3FF, 0, 2'd0, 10'h000, Z, "reset_idle1");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1;
      bus.Run = s.run; bus.raw_data = s.raw; clear = s.clr;
      @(negedge clk);
      e = sb.pop_front(); n_checks++;
      if ({bus.Tstep, bus.IR, bus.Imm, act} !== {e.ts, e.ir, e.imm, e.ctl}) begin
        n_errors++;
        $display("FAIL %s: got ts=%0d ir=%h imm=%h ctl=%h, expected ts=%0d ir=%h imm=%h ctl=%h",
                 e.nm, bus.Tstep, bus.IR, bus.Imm, act, e.ts, e.ir, e.imm, e.ctl);
      end
    end
  endtask

  task automatic test_ld();
    stim_t s; exp_t e;
    push(1, 10'h080, 0, 2'd0, 10'h000, mk(1,4'b0000,4'b0000,0,0,0,0,0,4'h0,0,0), "ld_t0");
    push(0, 10'h080, 0, 2'd1, 10'h080, mk(0,4'b0100,4'b0000,0,0,0,1,0,4'h0,1,0), "ld_t1");
    push(0, 10'h000, 0, 2'd0, 10'h080, Z, "ld_end");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1;
      bus.Run = s.run; bus.raw_data = s.raw; clear = s.clr;
      @(negedge clk);
      e = sb.pop_front(); n_checks++;
      if ({bus.Tstep, bus.IR, bus.Imm, act} !== {e.ts, e.ir, e.imm, e.ctl}) begin
        n_errors++;
        $display("FAIL %s: got ts=%0d ir=%h imm=%h ctl=%h, expected ts=%0d ir=%h imm=%h ctl=%h",
                 e.nm, bus.Tstep, bus.IR, bus.Imm, act, e.ts, e.ir, e.imm, e.ctl);
      end
    end
  endtask

  // Run stays high through T1/T2 and must be ignored there.
  task automatic test_add();
    stim_t s; exp_t e;
    push(1, 10'h072, 0, 2'd0, 10'h080, mk(1,4'b0000,4'b0000,0,0,0,0,0,4'h0,0,0), "add_t0");
    push(1, 10'h3FF, 0, 2'd1, 10'h072, mk(0,4'b0000,4'b0010,1,0,0,0,0,4'h2,0,0), "add_t1");
    push(1, 10'h3FF, 0, 2'd2, 10'h072, mk(0,4'b0000,4'b1000,0,1,0,0,0,4'h2,0,0), "add_t2");
    push(0, 10'h3FF, 0, 2'd3, 10'h072, mk(0,4'b0010,4'b0000,0,0,1,0,0,4'h2,1,0), "add_t3");
    push(0, 10'h000, 0, 2'd0, 10'h072, Z, "add_end");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1;
      bus.Run = s.run; bus.raw_data = s.raw; clear = s.clr;
      @(negedge clk);
      e = sb.pop_front(); n_checks++;
      if ({bus.Tstep, bus.IR, bus.Imm, act} !== {e.ts, e.ir, e.imm, e.ctl}) begin
        n_errors++;
        $display("FAIL %s: got ts=%0d ir=%h imm=%h ctl=%h, expected ts=%0d ir=%h imm=%h ctl=%h",
                 e.nm, bus.Tstep, bus.IR, bus.Imm, act, e.ts, e.ir, e.imm, e.ctl);
      end
    end
  endtask

  task automatic test_inv_subi();
    stim_t s; exp_t e;
    push(1, 10'h024, 0, 2'd0, 10'h072, mk(1,4'b0000,4'b0000,0,0,0,0,0,4'h0,0,0), "inv_t0");
    push(0, 10'h000, 0, 2'd1, 10'h024, mk(0,4'b0000,4'b0100,0,1,0,0,0,4'h4,0,0), "inv_t1");
    push(0, 10'h000, 0, 2'd2, 10'h024, mk(0,4'b0001,4'b0000,0,0,1,0,0,4'h4,1,0), "inv_t2");
    push(0, 10'h000, 0, 2'd0, 10'h024, Z, "inv_end");
    push(1, 10'h3EA, 0, 2'd0, 10'h024, mk(1,4'b0000,4'b0000,0,0,0,0,0,4'h0,0,0), "subi_t0");
    push(0, 10'h000, 0, 2'd1, 10'h3EA, mk(0,4'b0000,4'b1000,1,0,0,0,0,4'h3,0,0), "subi_t1");
    push(0, 10'h000, 0, 2'd2, 10'h3EA, mk(0,4'b0000,4'b0000,0,1,0,0,1,4'h3,0,0), "subi_t2");
    push(0, 10'h000, 0, 2'd3, 10'h3EA, mk(0,4'b1000,4'b0000,0,0,1,0,0,4'h3,1,0), "subi_t3");
    push(0, 10'h000, 0, 2'd0, 10'h3EA, Z, "subi_end");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1;
      bus.Run = s.run; bus.raw_data = s.raw; clear = s.clr;
      @(negedge clk);
      e = sb.pop_front(); n_checks++;
      if ({bus.Tstep, bus.IR, bus.Imm, act} !== {e.ts, e.ir, e.imm, e.ctl}) begin
        n_errors++;
        $display("FAIL %s: got ts=%0d ir=%h imm=%h ctl=%h, expected ts=%0d ir=%h imm=%h ctl=%h",
                 e.nm, bus.Tstep, bus.IR, bus.Imm, act, e.ts, e.ir, e.imm, e.ctl);
      end
    end
  endtask

  task automatic test_illegal();
    stim_t s; exp_t e;
    push(1, 10'h100, 0, 2'd0, 10'h3EA, mk(1,4'b0000,4'b0000,0,0,0,0,0,4'h0,0,0), "ill01_t0");
    push(0, 10'h000, 0, 2'd1, 10'h100, mk(0,4'b0000,4'b0000,0,0,0,0,0,4'h0,1,1), "ill01_t1");
    push(0, 10'h000, 0, 2'd0, 10'h100, Z, "ill01_end");
    push(1, 10'h00F, 0, 2'd0, 10'h100, mk(1,4'b0000,4'b0000,0,0,0,0,0,4'h0,0,0), "illF_t0");
    push(0, 10'h000, 0, 2'd1, 10'h00F, mk(0,4'b0000,4'b0000,0,0,0,0,0,4'hF,1,1), "illF_t1");
    push(0, 10'h000, 0, 2'd0, 10'h00F, Z, "illF_end");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1;
      bus.Run = s.run; bus.raw_data = s.raw; clear = s.clr;
      @(negedge clk);
      e = sb.pop_front(); n_checks++;
      if ({bus.Tstep, bus.IR, bus.Imm, act} !== {e.ts, e.ir, e.imm, e.ctl}) begin
        n_errors++;
        $display("FAIL %s: got ts=%0d ir=%h imm=%h ctl=%h, expected ts=%0d ir=%h imm=%h ctl=%h",
                 e.nm, bus.Tstep, bus.IR, bus.Imm, act, e.ts, e.ir, e.imm, e.ctl);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s; exp_t e;
    push(1, 10'h040, 0, 2'd0, 10'h00F, mk(1,4'b0000,4'b0000,0,0,0,0,0,4'h0,0,0), "b2b_ld_t0");
    push(1, 10'h011, 0, 2'd1, 10'h040, mk(0,4'b0010,4'b0000,0,0,0,1,0,4'h0,1,0), "b2b_ld_t1");
    push(1, 10'h011, 0, 2'd0, 10'h040, mk(1,4'b0000,4'b0000,0,0,0,0,0,4'h0,0,0), "b2b_cp_t0");
    push(0, 10'h000, 0, 2'd1, 10'h011, mk(0,4'b0001,4'b0010,0,0,0,0,0,4'h1,1,0), "b2b_cp_t1");
    push(0, 10'h000, 0, 2'd0, 10'h011, Z, "b2b_end");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1;
      bus.Run = s.run; bus.raw_data = s.raw; clear = s.clr;
      @(negedge clk);
      e = sb.pop_front(); n_checks++;
      if ({bus.Tstep, bus.IR, bus.Imm, act} !== {e.ts, e.ir, e.imm, e.ctl}) begin
        n_errors++;
        $display("FAIL %s: got ts=%0d ir=%h imm=%h ctl=%h, expected ts=%0d ir=%h imm=%h ctl=%h",
                 e.nm, bus.Tstep, bus.IR, bus.Imm, act, e.ts, e.ir, e.imm, e.ctl);
      end
    end
  endtask

  // Clear lands during T2 together with a Run request; the add must not complete.
  task automatic test_clear_mid();
    stim_t s; exp_t e;
    push(1, 10'h072, 0, 2'd0, 10'h011, mk(1,4'b0000,4'b0000,0,0,0,0,0,4'h0,0,0), "clr_t0");
    push(0, 10'h000, 0, 2'd1, 10'h072, mk(0,4'b0000,4'b0010,1,0,0,0,0,4'h2,0,0), "clr_t1");
    push(1, 10'h040, 1, 2'd2, 10'h072, mk(0,4'b0000,4'b1000,0,1,0,0,0,4'h2,0,0), "clr_t2");
    push(0, 10'h000, 0, 2'd0, 10'h000, Z, "clr_after0");
    push(0, 10'h3FF, 0, 2'd0, 10'h000, Z, "clr_after1");
    push(0, 10'h3FF, 0, 2'd0, 10'h000, Z, "clr_after2");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1;
      bus.Run = s.run; bus.raw_data = s.raw; clear = s.clr;
      @(negedge clk);
      e = sb.pop_front(); n_checks++;
      if ({bus.Tstep, bus.IR, bus.Imm, act} !== {e.ts, e.ir, e.imm, e.ctl}) begin
        n_errors++;
        $display("FAIL %s: got ts=%0d ir=%h imm=%h ctl=%h, expected ts=%0d ir=%h imm=%h ctl=%h",
                 e.nm, bus.Tstep, bus.IR, bus.Imm, act, e.ts, e.ir, e.imm, e.ctl);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    mon_en       = 1'b0;
    clear        = 1'b1;
    bus.Run      = 1'b0;
    bus.raw_data = '0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    test_reset();
    test_ld();
    test_add();
    test_inv_subi();
    test_illegal();
    test_back_to_back();
    test_clear_mid();
    mon_en = 1'b0;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/processor_controller.md
Name: processor_controller

Overview:
- Control unit of the 10-bit processor: holds the instruction register (IR) and the 2-bit timestep counter.
- Decodes the Table 1 instruction set and drives every datapath control signal: register file in/out enables, A/G latches, bus source selects and ALU function.
- Sits directly upstream of the datapath (register file, ALU, shared bus). Its IR and Tstep outputs also feed the DHEX/THEX display path.

Parameters:
- DATA_W, 10, width of the data bus and IR
- NREG, 4, number of general registers (R0–R3); one-hot enable width

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge
- Clear  in  1  synchronous, active-high reset
- Run  in  1  single-cycle execute strobe from the upstream edge detector; sampled only in T0
- raw_data  in  10  instruction word from the slide switches; latched into IR in T0
- IR  out  10  current instruction register contents
- Tstep  out  2  current timestep (0–3)
- IRin  out  1  IR load strobe (T0 & Run)
- Rin  out  4  one-hot register write enable
- Rout  out  4  one-hot register bus drive enable
- Ain  out  1  load ALU A register from bus
- Gin  out  1  load ALU G register from ALU result
- Gout  out  1  G drives bus
- Extern  out  1  raw_data drives bus
- Immout  out  1  immediate {4'b0000, IR[5:0]} drives bus
- Imm  out  10  zero-extended immediate value
- ALU_fn  out  4  ALU operation code
- Done  out  1  final step of the current instruction
- Illegal  out  1  asserted with Done when the opcode is undefined

Behaviour:
- State: IR[9:0] and Tstep[1:0], both registered.
- All control outputs are combinational from IR and Tstep (plus Run in T0).
- Clear (synchronous): next edge sets IR=0 and Tstep=0. All control outputs are then 0. Clear mid-instruction aborts it with no further register write and wins over Run.
- T0: if Run=1, assert IRin, IR<=raw_data, Tstep<=1. Otherwise hold with all outputs 0.
- Field decode: X=IR[7:6], Y=IR[5:4], fn=IR[3:0], class=IR[9:8].
- ld (class 00, fn 0000):
  - T1: Extern, Rin[X], Done.
- cp (fn 0001):
  - T1: Rout[Y], Rin[X], Done.
- inv (0100) and flp (0101), one operand, A step skipped:
  - T1: Rout[Y], Gin.
  - T2: Gout, Rin[X], Done.
- Two-operand ops (fn 0010, 0011, 0110–1011):
  - T1: Rout[X], Ain.
  - T2: Rout[Y], Gin.
  - T3: Gout, Rin[X], Done.
- addi (class 10) and subi (class 11):
  - T1: Rout[X], Ain.
  - T2: Immout, Gin.
  - T3: Gout, Rin[X], Done.
- ALU_fn for class 00 equals IR[3:0]. For addi it is 0010; for subi it is 0011. It is held valid through T1–T3.
- Illegal cases: class 01, or class 00 with fn 1100–1111. In T1: Done=1, Illegal=1, no Rin/Rout/Ain/Gin/bus driver; return to T0.
- Done cycle: Tstep<=0 on the next edge. Tstep never reaches a value beyond the instruction's last step.
- Run during T1–T3 is ignored.
- Run held high: a new IR load occurs in the T0 following Done (back-to-back execution).
- Bus invariant: at most one of Extern, Immout, Gout, |Rout is asserted per cycle. Rin and Rout are each one-hot or zero.
- Latency from Run to Done: ld/cp 1 cycle; inv/flp 2; ALU and immediate ops 3.

Test Plan:
- Reset:
  - Clear=1 during T2 of an add.
  - Required: next cycle Tstep=0, IR=0, all controls 0; Rin never asserted afterward.
- ld R2, raw_data=10'b00_10_000_0000, Run pulse.
  - T0: IRin=1.
  - T1: Extern=1, Rin=0100, Done=1.
  - Then Tstep=0.
- add R1,R3 (10'b00_01_11_0010).
  - T1: Rout=0010, Ain=1.
  - T2: Rout=1000, Gin=1, ALU_fn=0010.
  - T3: Gout=1, Rin=0010, Done=1.
- inv R0,R2 (10'b00_00_10_0100).
  - T1: Rout=0100, Gin=1, Ain=0.
  - T2: Gout=1, Rin=0001, Done=1.
  - Tstep never equals 3.
- subi R3,6'b101010 (10'b11_11_101010).
  - T2: Immout=1, Imm=10'b0000101010, ALU_fn=0011.
  - T3: Rin=1000, Done=1.
- Illegal and Run handling:
  - 10'b01_00_000000 and 10'b00_00_00_1111 each give Done=1, Illegal=1 in T1 with zero enables.
  - Run held high gives back-to-back instructions with a T0 between them.
  - Bus-invariant assertion holds throughout.
